// File: rtl/corescore_emitter_uart.sv
// corescore_emitter_uart
// Transmit-only 8N1 UART serializer for the console. A byte is accepted
// when i_valid meets o_ready. It is then sent as start(0), d0..d7 (LSB
// first), stop(1). Each bit is held for CLKS_PER_BIT system clocks.
// o_ready rises at the edge that ends the stop-bit period. The earliest
// next start bit therefore follows one cycle later.
module corescore_emitter_uart #(
    parameter int clk_freq_hz = 50_000_000,
    parameter int baud_rate   = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_uart_tx
);

    // Integer bit period in system clocks (truncated); must be at least 2.
    localparam int CLKS_PER_BIT = clk_freq_hz / baud_rate;
    localparam int BAUD_W       = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    // The bit counter indexes the bit currently on the line: 0 is start, 9 is stop.
    localparam logic [3:0] LAST_BIT = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_q,  state_d;
    logic        ready_q,  ready_d;
    logic [9:0]  shift_q,  shift_d;
    logic [3:0]  bit_q,    bit_d;
    logic [BAUD_W-1:0] baud_q, baud_d;

    // The line is bit 0 of the frame shift register. A flop therefore drives
    // the line directly. The all-ones fill keeps the line high in idle and
    // after the stop bit.
    assign o_uart_tx = shift_q[0];
    assign o_ready   = ready_q;

    // Next-state logic: accept a byte in idle, then pace the bits while busy.
    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        baud_d  = baud_q;

        case (state_q)
            ST_IDLE: begin
                // ready_q is high throughout idle, so i_valid alone decides acceptance.
                if (i_valid) begin
                    state_d = ST_BUSY;
                    ready_d = 1'b0;
                    // {stop, data, start}: the start bit appears on the line at once.
                    shift_d = {1'b1, i_data, 1'b0};
                    bit_d   = 4'd0;
                    baud_d  = '0;
                end
            end

            ST_BUSY: begin
                // i_valid and i_data are ignored here. Requests made while busy are dropped.
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        // The full stop-bit period has elapsed. The line stays high
                        // and becomes idle.
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        shift_d = '1;
                        bit_d   = 4'd0;
                    end else begin
                        // Present the next bit. Ones fill in from the top, so the
                        // register ends holding the stop level.
                        shift_d = {1'b1, shift_q[9:1]};
                        bit_d   = bit_q + 4'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                shift_d = '1;
                bit_d   = 4'd0;
                baud_d  = '0;
            end
        endcase
    end

    // State registers. Reset aborts any frame immediately and drives the line high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            shift_q <= '1;
            bit_q   <= 4'd0;
            baud_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
        end
    end

endmodule

// File: tb/tb_corescore_emitter_uart.sv
// Testbench for corescore_emitter_uart at 10 MHz / 1 Mbaud (10 clocks per bit).
// A time-indexed reference model predicts o_uart_tx and o_ready every cycle.
// A mid-bit sampling decoder recovers bytes and compares them with the
// accepted-byte queue.
module tb_corescore_emitter_uart;

    localparam int CLK_HZ = 10_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int FRAME  = 10 * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    corescore_emitter_uart #(
        .clk_freq_hz (CLK_HZ),
        .baud_rate   (BAUD)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_data    (data),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_uart_tx (tx)
    );

    // Single comparison point: count it and report any mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycle counter, used to time frame starts.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model. The line level is a function of the cycles elapsed
    // since acceptance: bit index = elapsed / CPB. The transmitter is busy
    // for 10*CPB cycles.
    logic       m_busy  = 1'b0;
    int         m_e     = 0;
    logic [9:0] m_frame = 10'h3FF;
    logic [7:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_e    <= 0;
            exp_q.delete();
        end else if (!m_busy) begin
            if (valid) begin
                m_busy  <= 1'b1;
                m_e     <= 0;
                m_frame <= {1'b1, data, 1'b0};
                exp_q.push_back(data);
            end
        end else begin
            if (m_e == FRAME - 1) m_busy <= 1'b0;
            m_e <= m_e + 1;
        end
    end

    // Per-cycle output check plus a UART decoder that samples mid-bit.
    logic       dec_active = 1'b0;
    int         dec_cnt    = 0;
    logic [7:0] dec_byte   = 8'h00;
    int         start_q[$];

    always @(negedge clk) begin
        check("tx", {31'd0, tx}, {31'd0, (m_busy ? m_frame[m_e / CPB] : 1'b1)});
        check("ready", {31'd0, ready}, {31'd0, ~m_busy});
        if (rst) begin
            dec_active <= 1'b0;
            dec_cnt    <= 0;
        end else if (!dec_active) begin
            if (!tx) begin
                dec_active <= 1'b1;
                dec_cnt    <= 1;
                start_q.push_back(cyc);
            end
        end else begin
            if (dec_cnt % CPB == CPB / 2) begin
                if (dec_cnt / CPB == 0)
                    check("dec_start", {31'd0, tx}, 32'd0);
                else if (dec_cnt / CPB <= 8)
                    dec_byte[dec_cnt / CPB - 1] <= tx;
                else begin
                    check("dec_stop", {31'd0, tx}, 32'd1);
                    if (exp_q.size() == 0)
                        check("dec_extra", 32'd1, 32'd0);
                    else
                        check("dec_byte", {24'd0, dec_byte}, {24'd0, exp_q.pop_front()});
                    dec_active <= 1'b0;
                end
            end
            dec_cnt <= dec_cnt + 1;
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, ready}, 32'd1);
    endtask

    task automatic pulse(input logic [7:0] b);
        @(negedge clk);
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ready", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;

        // 0x55: ready must stay low for exactly one frame.
        wait_ready("rdy_55");
        pulse(8'h55);
        n = 0;
        while (!ready && n < 3 * FRAME) begin
            n++;
            @(negedge clk);
        end
        check("busy_len", n, FRAME);

        // 'A': i_data changes just after acceptance must not leak into the frame.
        wait_ready("rdy_41");
        @(negedge clk);
        data  = 8'h41;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        data  = 8'hFF;
        wait_ready("rdy_41_done");

        // Back-to-back: hold i_valid with 0x00 then 0xFF; the starts are FRAME+1 apart.
        repeat (3) @(negedge clk);
        base = start_q.size();
        @(negedge clk);
        data  = 8'h00;
        valid = 1'b1;
        @(negedge clk);
        data  = 8'hFF;
        n = 0;
        while (start_q.size() < base + 2 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        valid = 1'b0;
        check("b2b_frames", start_q.size() - base, 2);
        if (start_q.size() >= base + 2)
            check("b2b_pitch", start_q[base + 1] - start_q[base], FRAME + 1);
        wait_ready("rdy_b2b");

        // A request made while busy is dropped.
        repeat (3) @(negedge clk);
        base = start_q.size();
        pulse(8'h12);
        repeat (20) @(negedge clk);
        pulse(8'h34);
        wait_ready("rdy_drop");
        repeat (30) @(negedge clk);
        check("drop_frames", start_q.size() - base, 1);

        // Reset during bit 4 (a low data bit): the line goes high immediately.
        pulse(8'hA5);
        n = 0;
        while (m_e < 4 * CPB + 3 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach", {31'd0, m_busy}, 32'd1);
        check("abort_low", {31'd0, tx}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx}, 32'd1);
        check("abort_ready", {31'd0, ready}, 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        pulse(8'h5A);
        wait_ready("rdy_5a");

        // Random traffic: sparse i_valid with random data, including requests while busy.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 7) == 0);
            data  = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        wait_ready("rdy_rand");
        repeat (FRAME) @(negedge clk);

        check("exp_left", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
